// File: rtl/mem_port_arbiter.sv
// N-port memory request arbiter: grants one requester at a time onto a single
// memory port, with a registered response path and an optional wait timeout.
module mem_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RR_MODE   = 1,
  parameter int TIMEOUT   = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS-1:0]          req_rw,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0] req_byte_en,
  output logic [NUM_PORTS-1:0]          resp_ready,
  output logic [DATA_W-1:0]             resp_rdata,
  output logic                          mem_request,
  output logic                          mem_rw,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [DATA_W-1:0]             mem_writeData,
  output logic [DATA_W/8-1:0]           mem_byte_en,
  input  logic [DATA_W-1:0]             mem_readData,
  input  logic                          mem_data_ready,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int BE_W = DATA_W / 8;
  localparam int IW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0]        TLIM_V  = TW'(TLIM);
  localparam logic [NUM_PORTS-1:0] ONE_HOT = NUM_PORTS'(1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          grant_q, grant_d;
  logic [IW-1:0]          last_grant_q, last_grant_d;
  logic                   mem_request_q, mem_request_d;
  logic                   mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]      mem_address_q, mem_address_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]        mem_be_q, mem_be_d;
  logic [NUM_PORTS-1:0]   resp_ready_q, resp_ready_d;
  logic [DATA_W-1:0]      resp_rdata_q, resp_rdata_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [TW-1:0]          tcount_q, tcount_d;

  logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0] wdata_arr [NUM_PORTS];
  logic [BE_W-1:0]   be_arr    [NUM_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
      assign be_arr[gi]    = req_byte_en[gi*BE_W +: BE_W];
    end
  endgenerate

  // Candidate search order: plain index order, or rotated to start just past
  // the previous winner so every waiting port is reached within NUM_PORTS-1 grants.
  logic [IW:0]   cand;
  logic [IW-1:0] grant_sel;
  logic          found;

  always_comb begin
    grant_sel = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (RR_MODE != 0) begin
        cand = {1'b0, last_grant_q} + (IW+1)'(k + 1);
        if (cand >= (IW+1)'(NUM_PORTS)) begin
          cand = cand - (IW+1)'(NUM_PORTS);
        end
      end else begin
        cand = (IW+1)'(k);
      end
      if (!found && req_valid[cand[IW-1:0]]) begin
        found     = 1'b1;
        grant_sel = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    mem_request_d = mem_request_q;
    mem_rw_d      = mem_rw_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    resp_ready_d  = '0;
    resp_rdata_d  = resp_rdata_q;
    timeout_err_d = 1'b0;
    tcount_d      = tcount_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d       = grant_sel;
          last_grant_d  = grant_sel;
          mem_rw_d      = req_rw[grant_sel];
          mem_address_d = addr_arr[grant_sel];
          mem_wdata_d   = wdata_arr[grant_sel];
          mem_be_d      = be_arr[grant_sel];
          mem_request_d = 1'b1;
          tcount_d      = '0;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        // A completion arriving on the expiry cycle still counts as a normal completion.
        if (mem_data_ready) begin
          mem_request_d = 1'b0;
          resp_rdata_d  = mem_rw_q ? '0 : mem_readData;
          resp_ready_d  = ONE_HOT << grant_q;
          state_d       = RESP;
        end else if ((TIMEOUT > 0) && (tcount_q == TLIM_V)) begin
          mem_request_d = 1'b0;
          resp_rdata_d  = '0;
          resp_ready_d  = ONE_HOT << grant_q;
          timeout_err_d = 1'b1;
          state_d       = RESP;
        end else begin
          tcount_d = tcount_q + 1'b1;
        end
      end
      RESP: begin
        resp_rdata_d = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_grant_q  <= IW'(NUM_PORTS - 1);
      mem_request_q <= 1'b0;
      mem_rw_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      resp_ready_q  <= '0;
      resp_rdata_q  <= '0;
      timeout_err_q <= 1'b0;
      tcount_q      <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      mem_request_q <= mem_request_d;
      mem_rw_q      <= mem_rw_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      resp_ready_q  <= resp_ready_d;
      resp_rdata_q  <= resp_rdata_d;
      timeout_err_q <= timeout_err_d;
      tcount_q      <= tcount_d;
    end
  end

  assign resp_ready    = resp_ready_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_request   = mem_request_q;
  assign mem_rw        = mem_rw_q;
  assign mem_address   = mem_address_q;
  assign mem_writeData = mem_wdata_q;
  assign mem_byte_en   = mem_be_q;
  assign busy          = (state_q != IDLE);
  assign timeout_err   = timeout_err_q;

endmodule
